muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in EX beside the ALU and takes the same rs/rt operands.
- Runs MULT/MULTU/DIV/DIVU over multiple cycles and writes HI/LO on completion. Also executes MTHI/MTLO.
- `hi`/`lo` feed the ALU's opA mux for MFHI/MFLO. `busy` drives the pipeline stall on HI/LO hazards.

---
 rtl/muldiv_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit with the architectural HI/LO registers. It
// sits in EX next to the ALU and receives the same rs/rt operands.
// MULT/MULTU/DIV/DIVU take one radix-2 step per cycle for WIDTH cycles, then
// one extra cycle for sign correction and the HI/LO write. MTHI/MTLO write
// HI/LO directly when the unit is idle.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset (clears HI/LO and kills any op)
//   start  - operation request, sampled only while idle
//   op     - 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 = no-op
//   opA    - rs: multiplicand / dividend / MTHI-MTLO source
//   opB    - rt: multiplier / divisor
//   abort  - pipeline flush; kills an in-flight op, blocks a start when idle
//   hi, lo - HI/LO registers (feed MFHI/MFLO through the ALU opA mux)
//   busy   - operation in flight; pipeline must stall HI/LO consumers
//   done   - one-cycle pulse, HI/LO were just written by a mul/div
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             abort,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Control state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Iteration datapath:
    //   multiply: {acc, quo} is the running product, quo starts as |multiplier|,
    //             opd holds |multiplicand|.
    //   divide:   acc is the partial remainder, quo shifts the dividend out and
    //             the quotient in, opd holds |divisor|.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             is_div_q, is_div_d;
    logic             res_neg_q, res_neg_d;   // negate product / quotient
    logic             rem_neg_q, rem_neg_d;   // negate remainder (dividend < 0)

    // Architectural registers
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Operand magnitudes for the signed ops. The most negative value maps to
    // itself, which is the correct magnitude when read as unsigned.
    logic             op_signed;
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] abs_a, abs_b;

    // One radix-2 step of each algorithm
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;

    // Final sign correction
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        op_signed = ~op[0];
        a_neg     = op_signed & opA[WIDTH-1];
        b_neg     = op_signed & opB[WIDTH-1];
        b_zero    = (opB == '0);
        abs_a     = a_neg ? -opA : opA;
        abs_b     = b_neg ? -opB : opB;

        mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opd_q} : '0);

        div_shift = {acc_q, quo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opd_q});
        div_trial = div_shift - {1'b0, opd_q};

        prod_mag  = {acc_q, quo_q};
        prod_fix  = res_neg_q ? -prod_mag : prod_mag;
        quo_fix   = res_neg_q ? -quo_q : quo_q;
        rem_fix   = rem_neg_q ? -acc_q : acc_q;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        opd_d     = opd_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    case (op)
                        OP_MTHI: hi_d = opA;
                        OP_MTLO: lo_d = opA;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d  = S_ITER;
                            cnt_d    = '0;
                            acc_d    = '0;
                            is_div_d = op[1];
                            if (op[1]) begin
                                quo_d = abs_a;
                                opd_d = abs_b;
                            end else begin
                                quo_d = abs_b;
                                opd_d = abs_a;
                            end
                            // Divide by zero leaves the all-ones quotient of the
                            // restoring loop uncorrected, and the remainder
                            // path rebuilds opA exactly from |opA| and its sign.
                            res_neg_d = (a_neg ^ b_neg) & ~(op[1] & b_zero);
                            rem_neg_d = op[1] & a_neg;
                        end
                        default: ;
                    endcase
                end
            end

            S_ITER: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        // Restoring step; the partial remainder always stays
                        // below the divisor, so WIDTH bits hold it.
                        acc_d = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], div_ge};
                    end else begin
                        // Shift-add: add multiplicand on multiplier LSB, then
                        // shift the whole {acc, quo} pair right by one.
                        acc_d = mul_sum[WIDTH:1];
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_FIN;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = is_div_q ? quo_fix : quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State registers. The datapath registers are reset along with control so
    // the whole unit comes out of reset in a known state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_q     <= '0;
            quo_q     <= '0;
            opd_q     <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // values computed from the previous cycle, independent of order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            opd_q     <= opd_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit (WIDTH=32). A transaction-level model
// computes results with plain 64-bit arithmetic and tracks when HI/LO, busy
// and done must change; a compare process checks the DUT against it on every
// falling edge. Directed sequences add literal expectations for each result.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd6;
    logic [31:0] opA   = '0;
    logic [31:0] opB   = '0;
    logic        abort = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .opA   (opA),
        .opB   (opB),
        .abort (abort),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one mul/div as {hi, lo}
    function automatic logic [63:0] ref_result(input logic [2:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        ref_result = '0;
        case (o)
            3'd0: ref_result = 64'(sa * sb);
            3'd1: ref_result = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) begin
                    ref_result = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_result = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 0) ref_result = {a, 32'hFFFF_FFFF};
                else        ref_result = {a % b, a / b};
            end
            default: ;
        endcase
    endfunction

    // Model: an accepted mul/div holds busy for 33 cycles, then writes HI/LO
    // with a one-cycle done; abort kills it, reset clears everything.
    logic [31:0] m_hi = '0, m_lo = '0, pend_hi = '0, pend_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (abort) begin
                    m_busy = 1'b0;
                end else if (m_left == 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_hi   = pend_hi;
                    m_lo   = pend_lo;
                end else begin
                    m_left--;
                end
            end else if (start && !abort) begin
                if (op == 3'd4) m_hi = opA;
                else if (op == 3'd5) m_lo = opA;
                else if (op <= 3'd3) begin
                    {pend_hi, pend_lo} = ref_result(op, opA, opB);
                    m_busy = 1'b1;
                    m_left = 33;
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        check("cyc_hi",   hi,   m_hi);
        check("cyc_lo",   lo,   m_lo);
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_done", 32'(done), 32'(m_done));
    end

    // Drive a one-cycle request at a falling edge; operands go random after.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; opA = a; opB = b;
        @(negedge clk);
        start = 1'b0; op = 3'd6; opA = $urandom; opB = $urandom;
    endtask

    task automatic wait_done(output int busy_cycles, output logic seen);
        busy_cycles = 0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   bc;
        logic seen;
        issue(o, a, b);
        wait_done(bc, seen);
        check({name, "_done"}, 32'(seen), 32'd1);
        check({name, "_busy_cycles"}, 32'(bc), 32'd33);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int   bc, dcount;
        logic seen;

        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
        // Issued in the done cycle of the previous op
        run_op("divu_b2b", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_neg",  3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_z",   3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_op("div_z",    3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

        // MTHI while idle
        @(negedge clk);
        issue(3'd4, 32'hDEAD_BEEF, 32'h0);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_busy", 32'(busy), 32'd0);

        // Requests while busy are ignored
        issue(3'd0, 32'd5, 32'd7);
        repeat (3) @(negedge clk);
        issue(3'd5, 32'h0000_1234, 32'h0);
        issue(3'd3, 32'd9, 32'd2);
        wait_done(bc, seen);
        check("ign_done", 32'(seen), 32'd1);
        check("ign_hi", hi, 32'h0);
        check("ign_lo", lo, 32'd35);

        // Abort mid-operation
        @(negedge clk);
        issue(3'd4, 32'h11, 32'h0);
        issue(3'd5, 32'h22, 32'h0);
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'h11);
        check("abort_lo", lo, 32'h22);
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        check("abort_hi_late", hi, 32'h11);

        // Start with abort while idle is ignored
        start = 1'b1; abort = 1'b1; op = 3'd4; opA = 32'h0BAD;
        @(negedge clk);
        start = 1'b0; abort = 1'b0; op = 3'd6;
        check("idle_abort_hi", hi, 32'h11);
        check("idle_abort_busy", 32'(busy), 32'd0);

        // Reset mid-operation
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_hi", hi, 32'h0);
        check("rstmid_lo", lo, 32'h0);
        check("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
